// File: rtl/fire_scheduler_if.sv
//------------------------------------------------------------------------------
// Module      : fire_scheduler_if
// Description : Excitation/fire handshake bundle between the circuit model
//               environment and the fire scheduler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fire_scheduler_if #(
  parameter int NT = 8,
  parameter int FW = 4
);
  logic [NT-1:0] i_enabled;
  logic          i_start;
  logic          i_stop;
  logic          i_mode;
  logic [FW-1:0] o_fire;
  logic          o_busy;
  logic          o_done;
  logic          o_deadlock;
  logic [15:0]   o_step_count;
  logic [FW-1:0] o_last_fired;

  modport slave (
    input  i_enabled, i_start, i_stop, i_mode,
    output o_fire, o_busy, o_done, o_deadlock, o_step_count, o_last_fired
  );

  modport master (
    output i_enabled, i_start, i_stop, i_mode,
    input  o_fire, o_busy, o_done, o_deadlock, o_step_count, o_last_fired
  );
endinterface

`default_nettype wire

// File: rtl/fire_scheduler.sv
//------------------------------------------------------------------------------
// Module      : fire_scheduler
// Description : Picks one excited transition per step (round-robin or LFSR
//               based) and pulses its index on the fire bus for one cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fire_scheduler #(
  parameter int          NT        = 8,
  parameter int          FW        = 4,
  parameter int          MAX_STEPS = 1024,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  fire_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_FIRE     = 3'd2,
    S_SETTLE   = 3'd3,
    S_DONE     = 3'd4,
    S_DEADLOCK = 3'd5
  } state_t;

  localparam logic [FW-1:0] c_IDLE     = FW'(NT);
  localparam logic [FW-1:0] c_LAST     = FW'(NT - 1);
  localparam logic [FW:0]   c_NT_EXT   = (FW + 1)'(NT);
  localparam logic [15:0]   c_LIMIT    = 16'(MAX_STEPS);
  localparam bit            c_LIMIT_ON = (MAX_STEPS != 0);

  state_t        r_state;
  logic [FW-1:0] r_fire;
  logic          r_busy;
  logic          r_done;
  logic          r_deadlock;
  logic [15:0]   r_step_count;
  logic [FW-1:0] r_last_fired;
  logic [FW-1:0] r_rr_ptr;
  logic [15:0]   r_lfsr;
  logic          r_mode_q;

  logic          w_fb;
  logic          w_any;
  logic [FW-1:0] w_lfsr_idx;
  logic [FW-1:0] w_base;
  logic [NT-1:0] w_rot;
  logic [FW-1:0] w_off;
  logic [FW:0]   w_sum;
  logic [FW-1:0] w_choice;
  logic [FW-1:0] w_next_rr;
  logic [15:0]   w_step_inc;
  logic          w_limit;

  assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_any      = |bus.i_enabled;
  assign w_lfsr_idx = r_lfsr[FW-1:0];
  // Out-of-range LFSR codes fall back to the round-robin pointer.
  assign w_base     = (r_mode_q && (w_lfsr_idx < c_IDLE)) ? w_lfsr_idx : r_rr_ptr;
  assign w_rot      = NT'({bus.i_enabled, bus.i_enabled} >> w_base);

  // Lowest set bit of the rotated vector is the first enabled index at/after base.
  always_comb begin
    w_off = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = FW'(i);
      end
    end
    w_sum    = {1'b0, w_base} + {1'b0, w_off};
    w_choice = (w_sum >= c_NT_EXT) ? FW'(w_sum - c_NT_EXT) : w_sum[FW-1:0];
  end

  assign w_next_rr  = (w_choice == c_LAST) ? '0 : w_choice + 1'b1;
  assign w_step_inc = (r_step_count != 16'hFFFF) ? r_step_count + 16'd1 : r_step_count;
  assign w_limit    = c_LIMIT_ON && (r_step_count == c_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_fire       <= c_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_deadlock   <= 1'b0;
      r_step_count <= '0;
      r_last_fired <= c_IDLE;
      r_rr_ptr     <= '0;
      r_lfsr       <= SEED;
      r_mode_q     <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      case (r_state)
        S_IDLE, S_DONE, S_DEADLOCK: begin
          if (bus.i_start) begin
            r_state      <= S_SELECT;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_deadlock   <= 1'b0;
            r_step_count <= '0;
            r_mode_q     <= bus.i_mode;
          end
        end
        S_SELECT: begin
          if (w_any) begin
            r_state      <= S_FIRE;
            r_fire       <= w_choice;
            r_last_fired <= w_choice;
            r_rr_ptr     <= w_next_rr;
            r_step_count <= w_step_inc;
          end else begin
            r_state    <= S_DEADLOCK;
            r_busy     <= 1'b0;
            r_deadlock <= 1'b1;
          end
        end
        S_FIRE: begin
          r_state <= S_SETTLE;
          r_fire  <= c_IDLE;
        end
        S_SETTLE: begin
          if (w_limit) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (bus.i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_SELECT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_fire  <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_fire       = r_fire;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_deadlock   = r_deadlock;
  assign bus.o_step_count = r_step_count;
  assign bus.o_last_fired = r_last_fired;

endmodule

`default_nettype wire

// File: tb/tb_fire_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_fire_scheduler
// Description : Scoreboard bench for fire_scheduler (default limit and a
//               4-step-limit instance).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fire_scheduler;

  localparam int NT = 8;
  localparam int FW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fire_scheduler_if #(.NT(NT), .FW(FW)) ifa ();
  fire_scheduler_if #(.NT(NT), .FW(FW)) ifb ();

  fire_scheduler #(.NT(NT), .FW(FW), .MAX_STEPS(1024), .SEED(16'hACE1)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  fire_scheduler #(.NT(NT), .FW(FW), .MAX_STEPS(4), .SEED(16'hACE1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [3:0] exp_a;
  logic [3:0] exp_b;
  int         hist[8];
  bit         mon_on = 1'b0;
  logic [15:0] m_lfsr;
  logic [3:0] m_rr_a;
  logic [3:0] m_rr_b;

  // Reference LFSR: Fibonacci, taps 16,14,13,11, reloaded while reset is low.
  always @(posedge clk) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [3:0] pick(input logic [7:0] en, input logic [3:0] base);
    logic [3:0] r;
    r = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      int j;
      j = (int'(base) + k) % 8;
      if (en[j]) r = 4'(j);
    end
    return r;
  endfunction

  function automatic logic [3:0] next_rr(input logic [3:0] c);
    return (c == 4'd7) ? 4'd0 : c + 4'd1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    tick;
    reset  = 1'b1;
    m_rr_a = 4'd0;
    m_rr_b = 4'd0;
  endtask

  always @(negedge clk) begin
    if (mon_on && ifa.o_fire !== 4'd8) begin
      n_tests++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL fire_a_unexpected: got %0d, want no fire", ifa.o_fire);
      end else begin
        exp_a = qa.pop_front();
        if (ifa.o_fire !== exp_a || ifa.o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL fire_a: got %0d busy %b, want %0d busy 1", ifa.o_fire, ifa.o_busy, exp_a);
        end
        if (ifa.o_fire < 4'd8) hist[ifa.o_fire]++;
      end
    end
    if (mon_on && ifb.o_fire !== 4'd8) begin
      n_tests++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL fire_b_unexpected: got %0d, want no fire", ifb.o_fire);
      end else begin
        exp_b = qb.pop_front();
        if (ifb.o_fire !== exp_b) begin
          n_fail++;
          $display("FAIL fire_b: got %0d, want %0d", ifb.o_fire, exp_b);
        end
      end
    end
  end

  // Runs n steps on instance A; stop is raised in the last SELECT.
  task automatic run_a(input int n, input logic [7:0] en, input logic m);
    logic [3:0] base;
    logic [3:0] e;
    ifa.i_enabled = en;
    ifa.i_mode    = m;
    ifa.i_start   = 1'b1;
    tick;
    ifa.i_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (m && m_lfsr[3:0] < 4'd8) base = m_lfsr[3:0];
      else                         base = m_rr_a;
      e = pick(en, base);
      qa.push_back(e);
      m_rr_a = next_rr(e);
      if (k == n - 1) ifa.i_stop = 1'b1;
      tick;
      n_tests++;
      if (ifa.o_fire === 4'd8) begin
        n_fail++;
        $display("FAIL fire_timing: got %0d, want %0d", ifa.o_fire, e);
      end
      tick;
      n_tests++;
      if (ifa.o_fire !== 4'd8) begin
        n_fail++;
        $display("FAIL fire_settle: got %0d, want 8", ifa.o_fire);
      end
      tick;
    end
    ifa.i_stop = 1'b0;
    n_tests++;
    if (ifa.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle: busy got %b, want 0", ifa.o_busy);
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_tests++;
    if (ifa.o_fire !== 4'd8 || ifa.o_busy !== 1'b0 || ifa.o_done !== 1'b0 || ifa.o_deadlock !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got fire %0d busy %b done %b dl %b, want 8 0 0 0",
               ifa.o_fire, ifa.o_busy, ifa.o_done, ifa.o_deadlock);
    end
    n_tests++;
    if (ifa.o_step_count !== 16'd0 || ifa.o_last_fired !== 4'd8) begin
      n_fail++;
      $display("FAIL reset_counts: got step %0d last %0d, want 0 8", ifa.o_step_count, ifa.o_last_fired);
    end
    n_tests++;
    if (ifb.o_fire !== 4'd8 || ifb.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: got fire %0d busy %b, want 8 0", ifb.o_fire, ifb.o_busy);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_round_robin;
    run_a(5, 8'b1010_0100, 1'b0);
    n_tests++;
    if (ifa.o_step_count !== 16'd5 || ifa.o_last_fired !== 4'd5) begin
      n_fail++;
      $display("FAIL rr_counts: got step %0d last %0d, want 5 5", ifa.o_step_count, ifa.o_last_fired);
    end
  endtask

  task automatic test_step_limit;
    ifb.i_enabled = 8'hFF;
    ifb.i_mode    = 1'b0;
    ifb.i_start   = 1'b1;
    tick;
    ifb.i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      qb.push_back(pick(8'hFF, m_rr_b));
      m_rr_b = next_rr(pick(8'hFF, m_rr_b));
      tick;
      if (k == 1) ifb.i_start = 1'b1;
      tick;
      ifb.i_start = 1'b0;
      tick;
    end
    n_tests++;
    if (ifb.o_done !== 1'b1 || ifb.o_busy !== 1'b0 || ifb.o_step_count !== 16'd4 || ifb.o_fire !== 4'd8) begin
      n_fail++;
      $display("FAIL limit_done: got done %b busy %b step %0d fire %0d, want 1 0 4 8",
               ifb.o_done, ifb.o_busy, ifb.o_step_count, ifb.o_fire);
    end
    ifb.i_start = 1'b1;
    tick;
    ifb.i_start = 1'b0;
    n_tests++;
    if (ifb.o_done !== 1'b0 || ifb.o_busy !== 1'b1 || ifb.o_step_count !== 16'd0) begin
      n_fail++;
      $display("FAIL limit_restart: got done %b busy %b step %0d, want 0 1 0",
               ifb.o_done, ifb.o_busy, ifb.o_step_count);
    end
    qb.push_back(4'd4);
    m_rr_b = 4'd5;
    ifb.i_stop = 1'b1;
    tick;
    tick;
    tick;
    ifb.i_stop = 1'b0;
    n_tests++;
    if (ifb.o_busy !== 1'b0 || ifb.o_step_count !== 16'd1 || ifb.o_last_fired !== 4'd4) begin
      n_fail++;
      $display("FAIL limit_stop: got busy %b step %0d last %0d, want 0 1 4",
               ifb.o_busy, ifb.o_step_count, ifb.o_last_fired);
    end
  endtask

  task automatic test_deadlock;
    logic [3:0] e;
    ifa.i_enabled = 8'hFF;
    ifa.i_mode    = 1'b0;
    ifa.i_start   = 1'b1;
    tick;
    ifa.i_start = 1'b0;
    e = 4'd8;
    for (int k = 0; k < 3; k++) begin
      e = pick(8'hFF, m_rr_a);
      qa.push_back(e);
      m_rr_a = next_rr(e);
      tick;
      if (k == 2) ifa.i_enabled = 8'h00;
      tick;
      tick;
    end
    tick;
    n_tests++;
    if (ifa.o_deadlock !== 1'b1 || ifa.o_busy !== 1'b0 || ifa.o_step_count !== 16'd3 ||
        ifa.o_last_fired !== e || ifa.o_fire !== 4'd8) begin
      n_fail++;
      $display("FAIL deadlock: got dl %b busy %b step %0d last %0d fire %0d, want 1 0 3 %0d 8",
               ifa.o_deadlock, ifa.o_busy, ifa.o_step_count, ifa.o_last_fired, ifa.o_fire, e);
    end
    ifa.i_enabled = 8'h01;
    ifa.i_start   = 1'b1;
    tick;
    ifa.i_start = 1'b0;
    n_tests++;
    if (ifa.o_deadlock !== 1'b0 || ifa.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL deadlock_clear: got dl %b busy %b, want 0 1", ifa.o_deadlock, ifa.o_busy);
    end
    qa.push_back(4'd0);
    m_rr_a = 4'd1;
    ifa.i_stop = 1'b1;
    tick;
    tick;
    tick;
    ifa.i_stop = 1'b0;
    n_tests++;
    if (ifa.o_last_fired !== 4'd0 || ifa.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL deadlock_recover: got last %0d busy %b, want 0 0", ifa.o_last_fired, ifa.o_busy);
    end
  endtask

  task automatic test_random;
    do_reset;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    run_a(1000, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (hist[i] < 60) begin
        n_fail++;
        $display("FAIL random_spread[%0d]: got %0d fires, want >= 60", i, hist[i]);
      end
    end
    do_reset;
    run_a(40, 8'hFF, 1'b1);
  endtask

  task automatic test_reset_midrun;
    ifa.i_enabled = 8'h20;
    ifa.i_mode    = 1'b0;
    ifa.i_start   = 1'b1;
    tick;
    ifa.i_start = 1'b0;
    qa.push_back(4'd5);
    tick;
    n_tests++;
    if (ifa.o_fire !== 4'd5) begin
      n_fail++;
      $display("FAIL midrun_fire: got %0d, want 5", ifa.o_fire);
    end
    reset = 1'b0;
    tick;
    n_tests++;
    if (ifa.o_fire !== 4'd8 || ifa.o_busy !== 1'b0 || ifa.o_step_count !== 16'd0 ||
        ifa.o_last_fired !== 4'd8 || ifa.o_done !== 1'b0 || ifa.o_deadlock !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got fire %0d busy %b step %0d last %0d done %b dl %b, want 8 0 0 8 0 0",
               ifa.o_fire, ifa.o_busy, ifa.o_step_count, ifa.o_last_fired, ifa.o_done, ifa.o_deadlock);
    end
    reset  = 1'b1;
    m_rr_a = 4'd0;
    m_rr_b = 4'd0;
    tick;
  endtask

  initial begin
    ifa.i_enabled = '0; ifa.i_start = 1'b0; ifa.i_stop = 1'b0; ifa.i_mode = 1'b0;
    ifb.i_enabled = '0; ifb.i_start = 1'b0; ifb.i_stop = 1'b0; ifb.i_mode = 1'b0;
    m_rr_a = 4'd0;
    m_rr_b = 4'd0;
    test_reset;
    test_round_robin;
    test_step_limit;
    test_deadlock;
    test_random;
    test_reset_midrun;
    tick;
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
